// File: rtl/smi_arb_pkg.sv
// Shared constants and types for the SMI stream arbiter: IOC register map,
// version/reset values and the FSM state encoding used in the status register.
package smi_arb_pkg;

  localparam logic [4:0] ADDR_VERSION = 5'h00;
  localparam logic [4:0] ADDR_CTRL    = 5'h01;
  localparam logic [4:0] ADDR_BURST   = 5'h02;
  localparam logic [4:0] ADDR_STATUS  = 5'h03;

  localparam logic [7:0] VERSION      = 8'h01;
  localparam logic [7:0] CTRL_RST     = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/smi_arb_regs.sv
// IOC register block for the SMI stream arbiter: control/burst registers,
// status readback and the one-cycle address-error pulse.
module smi_arb_regs
  import smi_arb_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic [4:0] ioc_i,
  input  logic [7:0] wdata_i,
  input  logic       cs_i,
  input  logic       fetch_i,
  input  logic       load_i,
  input  logic [1:0] state_i,
  input  logic       active_ch_i,
  output logic [7:0] rdata_o,
  output logic       addr_err_o,
  output logic       ch0_en_o,
  output logic       ch1_en_o,
  output logic       fixed_prio_o,
  output logic [7:0] burst_len_o
);

  logic [2:0] ctrl_q, ctrl_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       rd, wr, rd_mapped, wr_ok;
  logic [7:0] rd_val;

  assign rd = cs_i & fetch_i;
  assign wr = cs_i & load_i;

  always_comb begin
    rd_mapped = 1'b1;
    rd_val    = 8'h00;
    case (ioc_i)
      ADDR_VERSION: rd_val = VERSION;
      ADDR_CTRL:    rd_val = {5'b0, ctrl_q};
      ADDR_BURST:   rd_val = burst_q;
      ADDR_STATUS:  rd_val = {5'b0, state_i, active_ch_i};
      default:      rd_mapped = 1'b0;
    endcase
  end

  assign wr_ok = (ioc_i == ADDR_CTRL) || (ioc_i == ADDR_BURST);

  always_comb begin
    ctrl_d  = ctrl_q;
    burst_d = burst_q;
    rdata_d = rdata_q;
    err_d   = (rd & ~rd_mapped) | (wr & ~wr_ok);
    if (rd) rdata_d = rd_val;
    if (wr && ioc_i == ADDR_CTRL)  ctrl_d  = wdata_i[2:0];
    if (wr && ioc_i == ADDR_BURST) burst_d = wdata_i;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      ctrl_q  <= CTRL_RST[2:0];
      burst_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      burst_q <= burst_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign addr_err_o   = err_q;
  assign ch0_en_o     = ctrl_q[0];
  assign ch1_en_o     = ctrl_q[1];
  assign fixed_prio_o = ctrl_q[2];
  assign burst_len_o  = burst_q;

endmodule

// File: rtl/smi_stream_arbiter.sv
// Merges the two I/Q sample FIFOs onto one SMI readout FIFO interface,
// granting one channel at a time in bursts (round-robin or fixed priority).
module smi_stream_arbiter
  import smi_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic [4:0]  i_ioc,
  input  logic [7:0]  i_data_in,
  output logic [7:0]  o_data_out,
  input  logic        i_cs,
  input  logic        i_fetch_cmd,
  input  logic        i_load_cmd,
  input  logic        i_ch0_empty,
  input  logic        i_ch1_empty,
  input  logic [31:0] i_ch0_data,
  input  logic [31:0] i_ch1_data,
  output logic        o_ch0_pull,
  output logic        o_ch1_pull,
  output logic        o_fifo_empty,
  output logic [31:0] o_fifo_data,
  input  logic        i_fifo_pull,
  output logic        o_active_ch,
  output logic        o_address_error
);

  state_e     state_q, state_d;
  logic       active_ch_q, active_ch_d;
  logic       last_ch_q, last_ch_d;
  logic [8:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       hold_q, hold_d;

  logic       ch0_en, ch1_en, fixed_prio;
  logic [7:0] burst_len;
  logic       req0, req1, gnt_ch, gnt_empty, gnt_en;
  logic       in_stream, fwd, end_burst;

  smi_arb_regs u_regs (
    .i_sys_clk    (i_sys_clk),
    .i_rst_b      (i_rst_b),
    .ioc_i        (i_ioc),
    .wdata_i      (i_data_in),
    .cs_i         (i_cs),
    .fetch_i      (i_fetch_cmd),
    .load_i       (i_load_cmd),
    .state_i      (state_q),
    .active_ch_i  (active_ch_q),
    .rdata_o      (o_data_out),
    .addr_err_o   (o_address_error),
    .ch0_en_o     (ch0_en),
    .ch1_en_o     (ch1_en),
    .fixed_prio_o (fixed_prio),
    .burst_len_o  (burst_len)
  );

  assign req0      = ch0_en & ~i_ch0_empty;
  assign req1      = ch1_en & ~i_ch1_empty;
  assign gnt_ch    = (req0 & req1) ? (fixed_prio ? 1'b0 : ~last_ch_q) : req1;
  assign gnt_empty = active_ch_q ? i_ch1_empty : i_ch0_empty;
  assign gnt_en    = active_ch_q ? ch1_en : ch0_en;
  assign in_stream = (state_q == ST_STREAM);
  // A cleared enable stops forwarding from the first cycle it is visible.
  assign fwd       = in_stream & gnt_en & i_fifo_pull & ~gnt_empty;
  assign end_burst = (fwd & (burst_cnt_q == 9'd1))
                   | (gnt_empty & (to_cnt_q == 8'(TIMEOUT - 1)))
                   | ~gnt_en;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req0 | req1) state_d = ST_STREAM;
      ST_STREAM:  if (end_burst)   state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_q)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_fifo_empty = 1'b1;
    o_ch0_pull   = 1'b0;
    o_ch1_pull   = 1'b0;
    if (in_stream) begin
      o_fifo_empty = gnt_empty | ~gnt_en;
      o_ch0_pull   = fwd & ~active_ch_q;
      o_ch1_pull   = fwd &  active_ch_q;
    end
  end

  always_comb begin
    active_ch_d = active_ch_q;
    last_ch_d   = last_ch_q;
    burst_cnt_d = burst_cnt_q;
    to_cnt_d    = to_cnt_q;
    hold_d      = (state_q == ST_HOLDOFF) ? ~hold_q : 1'b0;
    case (state_q)
      ST_IDLE: if (req0 | req1) begin
        active_ch_d = gnt_ch;
        burst_cnt_d = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
        to_cnt_d    = 8'd0;
      end
      ST_STREAM: begin
        if (fwd) burst_cnt_d = burst_cnt_q - 9'd1;
        to_cnt_d = gnt_empty ? to_cnt_q + 8'd1 : 8'd0;
        if (end_burst) last_ch_d = active_ch_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      active_ch_q <= 1'b0;
      last_ch_q   <= 1'b1;
      burst_cnt_q <= 9'd0;
      to_cnt_q    <= 8'd0;
      hold_q      <= 1'b0;
    end else begin
      active_ch_q <= active_ch_d;
      last_ch_q   <= last_ch_d;
      burst_cnt_q <= burst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      hold_q      <= hold_d;
    end
  end

  assign o_fifo_data = active_ch_q ? i_ch1_data : i_ch0_data;
  assign o_active_ch = active_ch_q;

endmodule

// File: tb/tb_smi_stream_arbiter.sv
// Self-checking bench for smi_stream_arbiter: register vector table plus
// scoreboarded burst scenarios driven against modelled source FIFOs.
module tb_smi_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [4:0]  ioc;
  logic [7:0]  din, dout;
  logic        cs, fetch, load;
  logic        ch0_empty, ch1_empty;
  logic [31:0] ch0_data, ch1_data, fifo_data;
  logic        ch0_pull, ch1_pull, fifo_empty, fifo_pull, active_ch, addr_err;

  always #5 clk = ~clk;

  smi_stream_arbiter #(.TIMEOUT(16)) dut (
    .i_sys_clk(clk), .i_rst_b(rst_b), .i_ioc(ioc), .i_data_in(din),
    .o_data_out(dout), .i_cs(cs), .i_fetch_cmd(fetch), .i_load_cmd(load),
    .i_ch0_empty(ch0_empty), .i_ch1_empty(ch1_empty),
    .i_ch0_data(ch0_data), .i_ch1_data(ch1_data),
    .o_ch0_pull(ch0_pull), .o_ch1_pull(ch1_pull),
    .o_fifo_empty(fifo_empty), .o_fifo_data(fifo_data),
    .i_fifo_pull(fifo_pull), .o_active_ch(active_ch),
    .o_address_error(addr_err)
  );

  // Source FIFO models: limit is words made available, taken is words popped.
  int unsigned taken0, taken1, limit0, limit1;
  assign ch0_empty = (taken0 >= limit0);
  assign ch1_empty = (taken1 >= limit1);
  assign ch0_data  = 32'hC0DE_0000 + taken0;
  assign ch1_data  = 32'hBEEF_0000 + taken1;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      taken0 <= 0;
      taken1 <= 0;
    end else begin
      if (ch0_pull) taken0 <= taken0 + 1;
      if (ch1_pull) taken1 <= taken1 + 1;
    end
  end

  typedef struct {
    logic        ch;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int pulls_seen = 0, ch1_pulls = 0, empty_run = 0, last_gap = 0;
  logic prev_ch = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic ch, input int idx);
    exp_t e;
    e.ch   = ch;
    e.data = (ch ? 32'hBEEF_0000 : 32'hC0DE_0000) + 32'(idx);
    return e;
  endfunction

  // Monitor: every observed pop is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_b) begin
      if (fifo_empty) empty_run++;
      else begin
        if (empty_run != 0) last_gap = empty_run;
        empty_run = 0;
      end
      if (ch0_pull | ch1_pull) begin
        exp_t e;
        pulls_seen++;
        if (ch1_pull) ch1_pulls++;
        chk("pull_onehot", 32'(ch0_pull & ch1_pull), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pull ch=%0d data=%h", ch1_pull, fifo_data);
        end else begin
          e = sb.pop_front();
          chk("pull_ch", 32'(ch1_pull), 32'(e.ch));
          chk("pull_data", fifo_data, e.data);
        end
        if (pulls_seen > 1 && ch1_pull != prev_ch)
          chk("switch_gap_ge3", 32'(last_gap >= 3), 32'd1);
        prev_ch = ch1_pull;
      end
    end
  end

  task automatic do_reset();
    rst_b = 1'b0;
    cs = 0; fetch = 0; load = 0; ioc = 0; din = 0; fifo_pull = 0;
    limit0 = 0; limit1 = 0;
    sb.delete();
    pulls_seen = 0; ch1_pulls = 0; empty_run = 0; last_gap = 0;
    repeat (2) @(posedge clk);
    #3 rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  // Starts and ends one cycle past a rising edge; result is visible on return.
  task automatic reg_acc(input logic we, input logic [4:0] a, input logic [7:0] d);
    cs = 1; load = we; fetch = ~we; ioc = a; din = d;
    @(posedge clk); #1;
    cs = 0; load = 0; fetch = 0;
  endtask

  task automatic wait_pulls(input int n);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (pulls_seen >= n) break;
    end
    #1;
    if (pulls_seen < n) begin
      checks++;
      failures++;
      $display("FAIL wait_pulls actual=%0d required=%0d", pulls_seen, n);
    end
  endtask

  typedef struct {
    logic       we;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic       err;
  } vec_t;
  vec_t tv[16];

  initial begin
    tv[0]  = '{1'b0, 5'h00, 8'h00, 8'h01, 1'b0};
    tv[1]  = '{1'b0, 5'h01, 8'h00, 8'h03, 1'b0};
    tv[2]  = '{1'b0, 5'h02, 8'h00, 8'h00, 1'b0};
    tv[3]  = '{1'b0, 5'h03, 8'h00, 8'h00, 1'b0};
    tv[4]  = '{1'b0, 5'h07, 8'h00, 8'h00, 1'b1};
    tv[5]  = '{1'b1, 5'h00, 8'h55, 8'h00, 1'b1};
    tv[6]  = '{1'b0, 5'h00, 8'h00, 8'h01, 1'b0};
    tv[7]  = '{1'b1, 5'h02, 8'h05, 8'h00, 1'b0};
    tv[8]  = '{1'b0, 5'h02, 8'h00, 8'h05, 1'b0};
    tv[9]  = '{1'b1, 5'h03, 8'hFF, 8'h00, 1'b1};
    tv[10] = '{1'b1, 5'h01, 8'h07, 8'h00, 1'b0};
    tv[11] = '{1'b0, 5'h01, 8'h00, 8'h07, 1'b0};
    tv[12] = '{1'b1, 5'h1F, 8'h00, 8'h00, 1'b1};
    tv[13] = '{1'b0, 5'h1F, 8'h00, 8'h00, 1'b1};
    tv[14] = '{1'b1, 5'h01, 8'h03, 8'h00, 1'b0};
    tv[15] = '{1'b0, 5'h01, 8'h00, 8'h03, 1'b0};

    // Reset values and register map.
    do_reset();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);
    chk("rst_empty", 32'(fifo_empty), 32'h1);
    chk("rst_pulls", 32'({ch0_pull, ch1_pull}), 32'h0);
    chk("rst_active", 32'(active_ch), 32'h0);
    foreach (tv[i]) begin
      reg_acc(tv[i].we, tv[i].a, tv[i].d);
      chk($sformatf("vec%0d_err", i), 32'(addr_err), 32'(tv[i].err));
      if (!tv[i].we) chk($sformatf("vec%0d_data", i), 32'(dout), 32'(tv[i].exp));
      if (tv[i].err) begin
        @(posedge clk); #1;
        chk($sformatf("vec%0d_err_pulse", i), 32'(addr_err), 32'h0);
      end
    end

    // Round-robin bursts of 4: ch0, ch1, ch0.
    do_reset();
    reg_acc(1'b1, 5'h02, 8'd4);
    for (int k = 0; k < 4; k++) sb.push_back(mk(1'b0, k));
    for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, k));
    for (int k = 4; k < 8; k++) sb.push_back(mk(1'b0, k));
    limit0 = 1000; limit1 = 1000; fifo_pull = 1;
    wait_pulls(12);
    fifo_pull = 0;
    chk("rr_sb_drained", 32'(sb.size()), 32'd0);

    // Fixed priority: ch0 wins every grant.
    do_reset();
    reg_acc(1'b1, 5'h01, 8'h07);
    reg_acc(1'b1, 5'h02, 8'd2);
    for (int k = 0; k < 6; k++) sb.push_back(mk(1'b0, k));
    limit0 = 1000; limit1 = 1000; fifo_pull = 1;
    wait_pulls(6);
    fifo_pull = 0;
    chk("fp_no_ch1", 32'(ch1_pulls), 32'd0);
    chk("fp_sb_drained", 32'(sb.size()), 32'd0);

    // Empty timeout: 16 empty STREAM cycles, then 2 HOLDOFF, then IDLE.
    do_reset();
    reg_acc(1'b1, 5'h02, 8'd8);
    for (int k = 0; k < 3; k++) sb.push_back(mk(1'b0, k));
    limit0 = 3; limit1 = 0; fifo_pull = 1;
    wait_pulls(3);
    cs = 1; fetch = 1; ioc = 5'h03;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("to_status_c%0d", k), 32'(dout),
          (k <= 16) ? 32'h02 : (k <= 18) ? 32'h04 : 32'h00);
    end
    @(posedge clk); #1;
    cs = 0; fetch = 0; fifo_pull = 0;
    chk("to_sb_drained", 32'(sb.size()), 32'd0);

    // Pulls while empty are dropped and do not shorten the burst.
    do_reset();
    reg_acc(1'b1, 5'h02, 8'd3);
    for (int k = 0; k < 3; k++) sb.push_back(mk(1'b0, k));
    limit0 = 1; limit1 = 0; fifo_pull = 1;
    wait_pulls(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("drop_nopull%0d", k), 32'({ch0_pull, ch1_pull}), 32'h0);
      @(posedge clk); #1;
    end
    limit0 = 4;
    wait_pulls(2);
    @(negedge clk);
    chk("drop_mid_nonempty", 32'(fifo_empty), 32'h0);
    wait_pulls(3);
    fifo_pull = 0;
    @(negedge clk);
    chk("drop_end_empty", 32'(fifo_empty), 32'h1);
    @(posedge clk); #1;
    chk("drop_sb_drained", 32'(sb.size()), 32'd0);

    // Enable clear mid-burst, then asynchronous reset mid-burst.
    do_reset();
    reg_acc(1'b1, 5'h02, 8'd8);
    for (int k = 0; k < 3; k++) sb.push_back(mk(1'b0, k));
    for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, k));
    limit0 = 1000; limit1 = 1000; fifo_pull = 1;
    wait_pulls(2);
    cs = 1; load = 1; ioc = 5'h01; din = 8'h02;
    @(posedge clk); #1;
    cs = 0; load = 0;
    @(negedge clk);
    chk("en_clr_empty", 32'(fifo_empty), 32'h1);
    chk("en_clr_nopull", 32'(ch0_pull), 32'h0);
    chk("en_clr_fwd_in_write_cycle", 32'(pulls_seen), 32'd3);
    @(posedge clk); #1;
    reg_acc(1'b0, 5'h00, 8'h00);
    chk("en_clr_ver", 32'(dout), 32'h01);
    wait_pulls(7);
    chk("en_clr_sb_drained", 32'(sb.size()), 32'd0);
    rst_b = 1'b0;
    #1;
    chk("arst_empty", 32'(fifo_empty), 32'h1);
    chk("arst_pulls", 32'({ch0_pull, ch1_pull}), 32'h0);
    chk("arst_active", 32'(active_ch), 32'h0);
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_err", 32'(addr_err), 32'h0);
    @(posedge clk);
    #3 rst_b = 1'b1;
    fifo_pull = 0; limit0 = 0; limit1 = 0;
    @(posedge clk); #1;
    reg_acc(1'b0, 5'h03, 8'h00);
    chk("arst_status_idle", 32'(dout), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/smi_stream_arbiter.md
# smi_stream_arbiter

Sequences the two I/Q sample FIFOs (channel 0 = sub-GHz, channel 1 = 2.4 GHz) onto the single SMI readout path. It presents one FIFO-style interface to the SMI controller and grants it to one channel at a time, in bursts of configurable length, using round-robin or fixed priority. Configuration and status use the shared IOC register bus.

## Interface
- TIMEOUT, 16, consecutive empty cycles in STREAM that end a burst early (2..255)
- i_sys_clk  in  1  system clock
- i_rst_b  in  1  asynchronous, active-low reset
- i_ioc  in  5  register address
- i_data_in  in  8  write data
- o_data_out  out  8  read data, registered
- i_cs  in  1  module select
- i_fetch_cmd  in  1  read strobe
- i_load_cmd  in  1  write strobe
- i_ch0_empty, i_ch1_empty  in  1  source FIFO empty flags
- i_ch0_data, i_ch1_data  in  32  source FIFO head words
- o_ch0_pull, o_ch1_pull  out  1  source pop strobes
- o_fifo_empty  out  1  merged empty toward SMI controller
- o_fifo_data  out  32  merged head word
- i_fifo_pull  in  1  one-cycle pop from SMI controller
- o_active_ch  out  1  channel currently granted
- o_address_error  out  1  one-cycle pulse on access to unmapped IOC

## Operation
- Registers: 0x00 version, RO, 0x01. 0x01 control, RW: bit0 ch0_en, bit1 ch1_en, bit2 fixed_prio (1 = ch0 always wins), reset 0x03. 0x02 burst_len, RW, words per burst, 0 means 256, reset 0x00. 0x03 status, RO: {5'b0, state[1:0] encoding, o_active_ch}.
- Writes and reads are accepted only when i_cs=1. A write to an RO or unmapped address, or a read from an unmapped address, pulses o_address_error. Writes to RO addresses are otherwise ignored.
- The FSM has three states: IDLE, STREAM and HOLDOFF. Status encoding is 0, 1 and 2 respectively.
- **IDLE → STREAM** when an enabled channel is non-empty.
  - If only one channel requests, it is granted.
  - If both request with fixed_prio=1, ch0 is granted.
  - If both request with fixed_prio=0, the channel other than last_ch is granted. last_ch resets to 1, so ch0 is served first.
  - On grant: latch the channel into o_active_ch, load the 9-bit burst counter with burst_len (0 loads 256), and clear the empty-timeout counter.
- **In STREAM:**
  - o_fifo_data = granted channel data.
  - o_fifo_empty = granted channel empty.
  - i_fifo_pull is forwarded combinationally to the granted channel's pull only when that channel is non-empty. A pull arriving while empty is dropped and not counted.
  - Each forwarded pull decrements the burst counter.
- **STREAM → HOLDOFF**, with last_ch set to the granted channel, on any of:
  - a forwarded pull while the counter = 1;
  - TIMEOUT consecutive cycles with the granted channel empty;
  - the granted channel's enable bit reading 0.
- **HOLDOFF** lasts exactly 2 cycles, then returns to IDLE. This guarantees the downstream edge-based pull logic sees empty before a channel change.
- Outside STREAM: o_fifo_empty=1, both pulls are 0, o_fifo_data holds the last granted channel's data, and i_fifo_pull is ignored.
- A burst_len or enable write during STREAM affects the next grant only. The exception is clearing the granted channel's enable bit, which ends the burst as above.

## Timing
- Reset values: o_data_out=0, o_address_error=0, o_fifo_empty=1, pulls=0, o_active_ch=0, state IDLE.
- Reset is asynchronous and aborts any burst immediately. No pull is issued in the reset cycle.
- Grant latency: a request visible at edge N puts the FSM in STREAM after edge N. o_fifo_empty can drop in cycle N+1.
- Pull forwarding has zero latency: same-cycle combinational path from i_fifo_pull to o_chX_pull.
- After the final pull of a burst, o_fifo_empty=1 from the next cycle. The earliest next grant is 3 cycles after the final pull.
- Register read data appears one cycle after i_fetch_cmd. A write takes effect the cycle after i_load_cmd.
- Enable clear takes effect the cycle after the write. A pull in the write cycle is still forwarded.

## Structure
- Shared package smi_arb_pkg holds:
  - IOC address constants (0x00–0x03);
  - the module version constant 0x01;
  - the control reset value 0x03;
  - the state encoding.
- Sub-module smi_arb_regs holds the IOC decode, the control/burst registers, status readback and the address-error pulse.
- The FSM, counters and mux stay in the top level.

## Test plan
- Reset, then read 0x00, 0x01, 0x02 → 0x01, 0x03, 0x00. Read 0x07 → o_address_error pulses 1 cycle.
- burst_len=4, both channels always non-empty, 12 pulls at one per cycle → served ch0, ch1, ch0 (4 words each). Each change is preceded by ≥3 cycles of o_fifo_empty=1.
- fixed_prio=1, both non-empty, burst_len=2 → every grant goes to ch0. o_ch1_pull is never asserted.
- ch0 granted, burst_len=8, ch0 empties after 3 pulls → STREAM ends after exactly 16 empty cycles and the status state reads HOLDOFF, then IDLE.
- i_fifo_pull pulses while the granted channel is empty → no o_chX_pull and no counter decrement. The burst still ends after burst_len real pulls.
- Mid-burst, write control=0x02 (ch0 disabled) while ch0 is granted → the burst ends the next cycle and the next grant goes to ch1. Assert i_rst_b low mid-burst → all outputs return to reset values asynchronously.
